// File: rtl/kogge_stone_subtractor.sv
// Pipelined handshaked subtractor: diff = a - b over a registered Kogge-Stone borrow network.
// Optional signed overflow output enabled by defining KSS_OVF_EN.
module kogge_stone_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef KSS_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned L = $clog2(WIDTH);

    // Per-stage generate, group propagate, raw propagate and valid
    logic [L:0][WIDTH-1:0]   g_q,  g_d;
    logic [L-1:0][WIDTH-1:0] pg_q, pg_d;
    logic [L:0][WIDTH-1:0]   p_q,  p_d;
    logic [L:0]              v_q,  v_d;

    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             out_valid_q, out_valid_d;
`ifdef KSS_OVF_EN
    logic [L:0] am_q, am_d;
    logic [L:0] bm_q, bm_d;
    logic       overflow_q, overflow_d;
`endif

    logic adv;

    // Single global advance: whole pipeline moves or whole pipeline holds
    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    always_comb begin
        g_d         = g_q;
        pg_d        = pg_q;
        p_d         = p_q;
        v_d         = v_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        out_valid_d = out_valid_q;
`ifdef KSS_OVF_EN
        am_d        = am_q;
        bm_d        = bm_q;
        overflow_d  = overflow_q;
`endif
        if (adv) begin
            // Carry-in of 1 folds into bit 0's generate
            p_d[0]     = a ^ ~b;
            g_d[0]     = a & ~b;
            g_d[0][0]  = g_d[0][0] | p_d[0][0];
            pg_d[0]    = p_d[0];
            v_d[0]     = in_valid;

            for (int unsigned k = 1; k <= L; k++) begin
                p_d[k] = p_q[k-1];
                v_d[k] = v_q[k-1];
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (i >= (32'd1 << (k - 1)))
                        g_d[k][i] = g_q[k-1][i] |
                                    (pg_q[k-1][i] & g_q[k-1][i - (32'd1 << (k - 1))]);
                    else
                        g_d[k][i] = g_q[k-1][i];
                end
            end

            // Group propagate is only needed by levels below the last
            for (int unsigned k = 1; k < L; k++) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (i >= (32'd1 << (k - 1)))
                        pg_d[k][i] = pg_q[k-1][i] & pg_q[k-1][i - (32'd1 << (k - 1))];
                    else
                        pg_d[k][i] = pg_q[k-1][i];
                end
            end

            diff_d[0] = ~p_q[L][0];
            for (int unsigned i = 1; i < WIDTH; i++) begin
                diff_d[i] = p_q[L][i] ^ g_q[L][i-1];
            end
            borrow_d    = ~g_q[L][WIDTH-1];
            out_valid_d = v_q[L];

`ifdef KSS_OVF_EN
            am_d[0] = a[WIDTH-1];
            bm_d[0] = b[WIDTH-1];
            for (int unsigned k = 1; k <= L; k++) begin
                am_d[k] = am_q[k-1];
                bm_d[k] = bm_q[k-1];
            end
            overflow_d = (am_q[L] ^ bm_q[L]) & (am_q[L] ^ diff_d[WIDTH-1]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q         <= '0;
            pg_q        <= '0;
            p_q         <= '0;
            v_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef KSS_OVF_EN
            am_q        <= '0;
            bm_q        <= '0;
            overflow_q  <= 1'b0;
`endif
        end else begin
            g_q         <= g_d;
            pg_q        <= pg_d;
            p_q         <= p_d;
            v_q         <= v_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
`ifdef KSS_OVF_EN
            am_q        <= am_d;
            bm_q        <= bm_d;
            overflow_q  <= overflow_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
`ifdef KSS_OVF_EN
    assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_kogge_stone_subtractor.sv
// Directed bench for kogge_stone_subtractor (WIDTH = 16); overflow checks need KSS_OVF_EN.
module tb_kogge_stone_subtractor;

    localparam int unsigned W   = 16;
    localparam int          LAT = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef KSS_OVF_EN
    logic         overflow;
`endif

    int passed = 0;
    int total  = 0;

    kogge_stone_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef KSS_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Push one operand pair into an empty pipe and wait for its result
    task automatic send_one(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            output int lat, output logic [W-1:0] d,
                            output logic br, output logic ov);
        a         = ta;
        b         = tb_;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d  = diff;
        br = borrow;
`ifdef KSS_OVF_EN
        ov = overflow;
`else
        ov = 1'b0;
`endif
        idle(2);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready_during got=%b exp=1", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || diff !== 16'h0000 || borrow !== 1'b0)
            $display("FAIL reset_outputs got v=%b d=%h br=%b exp v=0 d=0000 br=0",
                     out_valid, diff, borrow);
        else passed++;
`ifdef KSS_OVF_EN
        total++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow);
        else passed++;
`endif
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after got=%b exp=1", in_ready);
        else passed++;
        idle(1);
    endtask

    task automatic test_single();
        int lat; logic [W-1:0] d; logic br; logic ov;
        send_one(16'h1234, 16'h0234, lat, d, br, ov);
        total++;
        if (lat !== LAT) $display("FAIL single_latency got=%0d exp=%0d", lat, LAT);
        else passed++;
        total++;
        if (d !== 16'h1000 || br !== 1'b0)
            $display("FAIL single_value got d=%h br=%b exp d=1000 br=0", d, br);
        else passed++;
`ifdef KSS_OVF_EN
        total++;
        if (ov !== 1'b0) $display("FAIL single_overflow got=%b exp=0", ov);
        else passed++;
`endif
    endtask

    task automatic test_borrow();
        logic [W-1:0] va [4] = '{16'h0000, 16'hFFFF, 16'h5555, 16'h0010};
        logic [W-1:0] vb [4] = '{16'h0001, 16'h0001, 16'hAAAA, 16'h0010};
        logic [W-1:0] vd [4] = '{16'hFFFF, 16'hFFFE, 16'hAAAB, 16'h0000};
        logic         vbr[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int lat; logic [W-1:0] d; logic br; logic ov;
        for (int i = 0; i < 4; i++) begin
            send_one(va[i], vb[i], lat, d, br, ov);
            total++;
            if (d !== vd[i] || br !== vbr[i] || lat !== LAT)
                $display("FAIL borrow_vec%0d got d=%h br=%b lat=%0d exp d=%h br=%b lat=%0d",
                         i, d, br, lat, vd[i], vbr[i], LAT);
            else passed++;
`ifdef KSS_OVF_EN
            if (i == 0) begin
                total++;
                if (ov !== 1'b0) $display("FAIL borrow_overflow got=%b exp=0", ov);
                else passed++;
            end
`endif
        end
    endtask

`ifdef KSS_OVF_EN
    task automatic test_overflow();
        int lat; logic [W-1:0] d; logic br; logic ov;
        send_one(16'h8000, 16'h0001, lat, d, br, ov);
        total++;
        if (d !== 16'h7FFF || br !== 1'b0 || ov !== 1'b1)
            $display("FAIL ovf_neg got d=%h br=%b ov=%b exp d=7fff br=0 ov=1", d, br, ov);
        else passed++;
        send_one(16'h7FFF, 16'hFFFF, lat, d, br, ov);
        total++;
        if (d !== 16'h8000 || br !== 1'b1 || ov !== 1'b1)
            $display("FAIL ovf_pos got d=%h br=%b ov=%b exp d=8000 br=1 ov=1", d, br, ov);
        else passed++;
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] qd[$];
        logic         qb[$];
        int sent = 0, recv = 0, first_cyc = -1, last_cyc = -1, errs = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 130; cyc++) begin
            if (sent < 100) begin
                a        = W'($urandom);
                b        = W'($urandom);
                in_valid = 1'b1;
                qd.push_back(a - b);
                qb.push_back(a < b);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                recv++;
                total++;
                if (qd.size() == 0) begin
                    $display("FAIL b2b_extra result d=%h exp none", diff);
                    errs++;
                end else begin
                    if (diff !== qd[0] || borrow !== qb[0])
                        $display("FAIL b2b_result%0d got d=%h br=%b exp d=%h br=%b",
                                 recv, diff, borrow, qd[0], qb[0]);
                    else passed++;
                    void'(qd.pop_front());
                    void'(qb.pop_front());
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (recv !== 100 || errs != 0) $display("FAIL b2b_count got=%0d exp=100", recv);
        else passed++;
        total++;
        if (last_cyc - first_cyc !== 99)
            $display("FAIL b2b_spacing got span=%0d exp=99", last_cyc - first_cyc);
        else passed++;
        idle(2);
    endtask

    task automatic test_stall();
        localparam int N = 60;
        logic [W-1:0] qd[$];
        logic         qb[$];
        logic [W-1:0] hold_d;
        logic         hold_b, stalled, acc;
        int sent = 0, recv = 0, cyc = 0, rdy_err = 0, stab_err = 0;
        a        = W'($urandom);
        b        = W'($urandom);
        in_valid = 1'b1;
        while (recv < N && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready !== ~(out_valid & ~out_ready)) rdy_err++;
            acc = in_valid & in_ready;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                recv++;
                total++;
                if (qd.size() == 0) begin
                    $display("FAIL stall_extra result d=%h exp none", diff);
                end else begin
                    if (diff !== qd[0] || borrow !== qb[0])
                        $display("FAIL stall_result%0d got d=%h br=%b exp d=%h br=%b",
                                 recv, diff, borrow, qd[0], qb[0]);
                    else passed++;
                    void'(qd.pop_front());
                    void'(qb.pop_front());
                end
            end
            if (acc) begin
                qd.push_back(a - b);
                qb.push_back(a < b);
            end
            stalled = out_valid & ~out_ready;
            hold_d  = diff;
            hold_b  = borrow;
            @(posedge clk);
            #1;
            if (stalled && (out_valid !== 1'b1 || diff !== hold_d || borrow !== hold_b))
                stab_err++;
            if (acc) begin
                sent++;
                if (sent < N) begin
                    a = W'($urandom);
                    b = W'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (recv !== N || qd.size() != 0)
            $display("FAIL stall_count got=%0d left=%0d exp=%0d left=0", recv, qd.size(), N);
        else passed++;
        total++;
        if (rdy_err != 0) $display("FAIL stall_in_ready got errors=%0d exp=0", rdy_err);
        else passed++;
        total++;
        if (stab_err != 0) $display("FAIL stall_stability got errors=%0d exp=0", stab_err);
        else passed++;
        idle(4);
    endtask

    task automatic test_mid_reset();
        int lat, seen = 0; logic [W-1:0] d; logic br; logic ov;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'h1000 + W'(i);
            b = 16'h0001;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midrst_state got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        else passed++;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL midrst_flush got valid_cycles=%0d exp=0", seen);
        else passed++;
        send_one(16'hABCD, 16'hABCD, lat, d, br, ov);
        total++;
        if (lat !== LAT || d !== 16'h0000 || br !== 1'b0)
            $display("FAIL midrst_next got lat=%0d d=%h br=%b exp lat=%0d d=0000 br=0",
                     lat, d, br, LAT);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_borrow();
`ifdef KSS_OVF_EN
        test_overflow();
`endif
        test_back_to_back();
        test_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/kogge_stone_subtractor.md
# kogge_stone_subtractor

Pipelined, handshaked two's-complement subtractor computing `diff = a - b` over a Kogge-Stone parallel-prefix borrow network, with one register per prefix level. It is the subtract-direction counterpart to the team's combinational 16-bit Kogge-Stone adder. It targets datapaths that need a registered, backpressure-aware difference and an unsigned borrow/compare result at full clock rate.

## Interface
- `WIDTH`, 16, operand width; power of two, 4..32; prefix levels `L = log2(WIDTH)`
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `in_valid`  in  1  operand pair `a`/`b` present
- `in_ready`  out  1  block accepts operands this cycle
- `a`  in  WIDTH  minuend, unsigned or two's complement
- `b`  in  WIDTH  subtrahend
- `out_valid`  out  1  `diff`/`borrow` valid
- `out_ready`  in  1  downstream accepts result this cycle
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`
- `borrow`  out  1  1 when `a < b` unsigned, i.e. the inverted carry-out
- `overflow`  out  1  signed overflow; present only with `KSS_OVF_EN`

## Operation
- Pipeline stage S0 (input register) captures per-bit propagate `p[i] = a[i] ^ ~b[i]` and generate `g[i] = a[i] & ~b[i]`.
- Carry-in is constant 1: the stored `g[0]` is `g[0] | p[0]`.
- S0 also keeps `p` unmodified for sum formation.
- Prefix stages S1..SL: level k (distance `d = 2^(k-1)`) computes, for `i >= d`:
  - `G' = G[i] | (P[i] & G[i-d])`
  - `P' = P[i] & P[i-d]`
- For `i < d`, bits pass through unchanged.
- Each level is registered, and the original `p` vector travels alongside it.
- Final stage SL+1 registers:
  - `diff[0] = ~p[0]`
  - `diff[i] = p[i] ^ G[i-1]` for `i >= 1`
  - `borrow = ~G[WIDTH-1]`
- Handshake: one global advance enable `adv = ~out_valid | out_ready`, and `in_ready = adv`.
- When `adv` is high, every stage loads from its predecessor and per-stage valid bits shift.
- S0 valid loads `in_valid`.
- When `adv` is low, all stages hold.
- Bubbles are not compacted, so throughput is 1 result per cycle when `out_ready` is held high.
- A transfer occurs only when valid and ready are high together, on either side.
- `diff`, `borrow` and `overflow` stay stable while `out_valid & ~out_ready`.
- No arithmetic exceptions:
  - `a == b` gives `diff = 0`, `borrow = 0`.
  - Wrap-around is modulo `2^WIDTH`.

## Timing
- Latency is `L + 2` cycles from the accepting edge to `out_valid` (6 for `WIDTH = 16`).
- Reset:
  - All stage valid bits go to 0.
  - `out_valid`, `diff`, `borrow` and `overflow` are 0 on the cycle after the reset edge.
  - `in_ready` reads 1 during and after reset.
- Reset mid-operation discards all in-flight operands with no output produced. The first operand accepted after reset emerges `L + 2` cycles later.
- With the pipeline full and `out_ready = 0`, `in_ready` goes low combinationally. Any `in_valid` that cycle is not accepted, and the upstream must hold it.
- Simultaneous `out_ready` rise and `in_valid`: the output is consumed and the new operand accepted on the same edge.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `a`/`b` to the outputs.

## Configuration
- `KSS_OVF_EN` defined:
  - S0 additionally carries `a[WIDTH-1]` and `b[WIDTH-1]` down the pipeline.
  - The final stage registers `overflow = (a_msb ^ b_msb) & (a_msb ^ diff[WIDTH-1])`.
  - `overflow` resets to 0 and holds under stall like `diff`.
- `KSS_OVF_EN` undefined: the `overflow` port and its pipeline bits are absent, and the block is otherwise identical.

## Test plan
- Reset then single op, `a = 16'h1234`, `b = 16'h0234`, `out_ready = 1`: `out_valid` rises exactly 6 cycles after acceptance, with `diff = 16'h1000`, `borrow = 0`.
- `a = 16'h0000`, `b = 16'h0001`: `diff = 16'hFFFF`, `borrow = 1`. With the macro, `overflow = 0`.
- Macro on, `a = 16'h8000`, `b = 16'h0001`: `diff = 16'h7FFF`, `borrow = 0`, `overflow = 1`. Also `a = 16'h7FFF`, `b = 16'hFFFF`: `diff = 16'h8000`, `overflow = 1`.
- Back-to-back stream of 100 random pairs, `out_ready = 1`: 100 results in order, one per cycle, each matching `a - b` and `a < b`.
- Stream with `out_ready` randomly toggled at 50%: no result lost or duplicated, and outputs stable while stalled. `in_ready` is 0 exactly when `out_valid & ~out_ready`.
- Assert `rst` for one cycle with 4 ops in flight: no `out_valid` for the flushed ops, and the next accepted op (`a = b = 16'hABCD`) yields `diff = 0`, `borrow = 0` after 6 cycles.
